// File: rtl/imdct_pkg.sv
// Shared types and widths for the IMDCT block-floating-point datapath.
package imdct_pkg;

    localparam int SAMPLE_W = 32;
    localparam int SHIFT_W  = 5;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/barrel_shifter32_left.sv
// Combinational 32-bit logical left shifter; the mirror of the arithmetic right shifter.
module barrel_shifter32_left
    import imdct_pkg::*;
(
    input  sample_t              i_data,
    input  logic [SHIFT_W-1:0]   i_ctrl,
    output sample_t              o_data
);

    logic [SAMPLE_W-1:0] w_s0;
    logic [SAMPLE_W-1:0] w_s1;
    logic [SAMPLE_W-1:0] w_s2;
    logic [SAMPLE_W-1:0] w_s3;

    // log2 stages: each ctrl bit moves the word by its binary weight
    assign w_s0   = i_ctrl[0] ? {i_data[30:0], 1'b0}     : i_data;
    assign w_s1   = i_ctrl[1] ? {w_s0[29:0], 2'b00}      : w_s0;
    assign w_s2   = i_ctrl[2] ? {w_s1[27:0], 4'h0}       : w_s1;
    assign w_s3   = i_ctrl[3] ? {w_s2[23:0], 8'h00}      : w_s2;
    assign o_data = i_ctrl[4] ? {w_s3[15:0], 16'h0000}   : w_s3;

endmodule

// File: rtl/imdct_block_normalizer.sv
// Block-floating-point normalizer: buffers a block, finds common headroom,
// and drains it left-shifted by that headroom together with the exponent.
module imdct_block_normalizer
    import imdct_pkg::*;
#(
    parameter int BLOCK_LEN = 18,
    parameter int MAX_SHIFT = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  sample_t              in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output sample_t              out_data,
    output logic [SHIFT_W-1:0]   out_shift,
    output logic                 out_last
);

    localparam int                 CNT_W     = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(BLOCK_LEN - 1);
    localparam logic [SHIFT_W-1:0] SHIFT_CAP = SHIFT_W'(MAX_SHIFT);
    localparam logic [SHIFT_W-1:0] HR_INIT   = {SHIFT_W{1'b1}};

    // Redundant sign bits: bits below the MSB that still match it, stopping at the first mismatch.
    function automatic logic [SHIFT_W-1:0] headroom(input sample_t x);
        logic [SHIFT_W-1:0] cnt;
        logic               done;
        cnt  = {SHIFT_W{1'b0}};
        done = 1'b0;
        for (int i = SAMPLE_W - 2; i >= 0; i--) begin
            if (!done && (x[i] == x[SAMPLE_W-1])) begin
                cnt = cnt + SHIFT_W'(1);
            end else begin
                done = 1'b1;
            end
        end
        return cnt;
    endfunction

    state_t               r_state;
    logic [CNT_W-1:0]     r_wr_cnt;
    logic [CNT_W-1:0]     r_rd_cnt;
    logic [SHIFT_W-1:0]   r_min_hr;
    logic [SHIFT_W-1:0]   r_shift;
    sample_t              r_buf [BLOCK_LEN];

    state_t               w_state_next;
    logic [CNT_W-1:0]     w_wr_cnt_next;
    logic [CNT_W-1:0]     w_rd_cnt_next;
    logic [SHIFT_W-1:0]   w_min_hr_next;
    logic [SHIFT_W-1:0]   w_shift_next;
    logic                 w_buf_we;
    logic                 w_in_hs;
    logic                 w_out_hs;
    logic [SHIFT_W-1:0]   w_hr;
    logic [SHIFT_W-1:0]   w_min_cand;
    logic [SHIFT_W-1:0]   w_shift_clamped;

    assign in_ready        = (r_state == FILL);
    assign out_valid       = (r_state == DRAIN);
    assign out_last        = out_valid && (r_rd_cnt == LAST_IDX);
    assign out_shift       = r_shift;
    assign w_in_hs         = in_valid && in_ready;
    assign w_out_hs        = out_valid && out_ready;
    assign w_hr            = headroom(in_data);
    assign w_min_cand      = (w_hr < r_min_hr) ? w_hr : r_min_hr;
    assign w_shift_clamped = (w_min_cand > SHIFT_CAP) ? SHIFT_CAP : w_min_cand;

    barrel_shifter32_left u_shift (
        .i_data (r_buf[r_rd_cnt]),
        .i_ctrl (r_shift),
        .o_data (out_data)
    );

    // Next-state and counter/exponent update; flush overrides any handshake.
    always_comb begin
        w_state_next  = r_state;
        w_wr_cnt_next = r_wr_cnt;
        w_rd_cnt_next = r_rd_cnt;
        w_min_hr_next = r_min_hr;
        w_shift_next  = r_shift;
        w_buf_we      = 1'b0;
        if (flush) begin
            w_state_next  = FILL;
            w_wr_cnt_next = {CNT_W{1'b0}};
            w_rd_cnt_next = {CNT_W{1'b0}};
            w_min_hr_next = HR_INIT;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_in_hs) begin
                        w_buf_we      = 1'b1;
                        w_min_hr_next = w_min_cand;
                        if (r_wr_cnt == LAST_IDX) begin
                            w_state_next = DRAIN;
                            w_shift_next = w_shift_clamped;
                        end else begin
                            w_wr_cnt_next = r_wr_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_next = FILL;
                    end
                end
                DRAIN: begin
                    if (w_out_hs) begin
                        if (r_rd_cnt == LAST_IDX) begin
                            w_state_next  = FILL;
                            w_wr_cnt_next = {CNT_W{1'b0}};
                            w_rd_cnt_next = {CNT_W{1'b0}};
                            w_min_hr_next = HR_INIT;
                        end else begin
                            w_rd_cnt_next = r_rd_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_next = DRAIN;
                    end
                end
                default: begin
                    w_state_next  = FILL;
                    w_wr_cnt_next = {CNT_W{1'b0}};
                    w_rd_cnt_next = {CNT_W{1'b0}};
                    w_min_hr_next = HR_INIT;
                end
            endcase
        end
    end

    // State, counters and exponent registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FILL;
            r_wr_cnt <= {CNT_W{1'b0}};
            r_rd_cnt <= {CNT_W{1'b0}};
            r_min_hr <= HR_INIT;
            r_shift  <= {SHIFT_W{1'b0}};
        end else begin
            r_state  <= w_state_next;
            r_wr_cnt <= w_wr_cnt_next;
            r_rd_cnt <= w_rd_cnt_next;
            r_min_hr <= w_min_hr_next;
            r_shift  <= w_shift_next;
        end
    end

    // Sample buffer; written only on an accepted, non-flushed input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BLOCK_LEN; i++) begin
                r_buf[i] <= {SAMPLE_W{1'b0}};
            end
        end else if (w_buf_we) begin
            r_buf[r_wr_cnt] <= in_data;
        end else begin
            r_buf[r_wr_cnt] <= r_buf[r_wr_cnt];
        end
    end

endmodule

// File: tb/tb_imdct_block_normalizer.sv
// Directed bench with a block-level reference model for imdct_block_normalizer.
module tb_imdct_block_normalizer;

    localparam int BL = 18;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_last;
    logic [31:0] out_data;
    logic [4:0]  out_shift;
    logic        in_ready8, out_valid8, out_last8;
    logic [31:0] out_data8;
    logic [4:0]  out_shift8;

    int checks = 0;
    int errors = 0;

    logic [31:0] blk_in [BL];

    imdct_block_normalizer #(.BLOCK_LEN(BL), .MAX_SHIFT(31)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_shift(out_shift), .out_last(out_last)
    );

    imdct_block_normalizer #(.BLOCK_LEN(BL), .MAX_SHIFT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .out_shift(out_shift8), .out_last(out_last8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Headroom as the largest k for which an arithmetic round trip by k is lossless.
    function automatic int model_hr(input logic [31:0] x);
        logic signed [31:0] t;
        logic signed [31:0] s;
        t = x;
        for (int k = 31; k >= 0; k--) begin
            s = t <<< k;
            if ((s >>> k) == t) return k;
        end
        return 0;
    endfunction

    logic [31:0] m_blk[$];
    logic [31:0] m_q[$];
    logic [31:0] m_q8[$];
    logic [4:0]  m_sh, m_sh8;
    bit          m_drain;

    // Reference model and per-cycle comparison for both instances.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_last", {31'd0, out_last}, 32'd0);
            chk("rst_out_shift", {27'd0, out_shift}, 32'd0);
            chk("rst8_out_valid", {31'd0, out_valid8}, 32'd0);
            m_blk.delete(); m_q.delete(); m_q8.delete();
            m_drain = 1'b0;
        end else begin
            if (!m_drain) begin
                chk("fill_in_ready", {31'd0, in_ready}, 32'd1);
                chk("fill_out_valid", {31'd0, out_valid}, 32'd0);
                chk("fill8_in_ready", {31'd0, in_ready8}, 32'd1);
                chk("fill8_out_valid", {31'd0, out_valid8}, 32'd0);
            end else begin
                chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
                chk("drain_out_valid", {31'd0, out_valid}, 32'd1);
                chk("drain_data", out_data, m_q[0]);
                chk("drain_shift", {27'd0, out_shift}, {27'd0, m_sh});
                chk("drain_last", {31'd0, out_last}, {31'd0, m_q.size() == 1});
                chk("drain8_in_ready", {31'd0, in_ready8}, 32'd0);
                chk("drain8_out_valid", {31'd0, out_valid8}, 32'd1);
                chk("drain8_data", out_data8, m_q8[0]);
                chk("drain8_shift", {27'd0, out_shift8}, {27'd0, m_sh8});
                chk("drain8_last", {31'd0, out_last8}, {31'd0, m_q8.size() == 1});
            end
            if (flush) begin
                m_blk.delete(); m_q.delete(); m_q8.delete();
                m_drain = 1'b0;
            end else if (!m_drain && in_valid) begin
                m_blk.push_back(in_data);
                if (m_blk.size() == BL) begin
                    int mn;
                    mn = 31;
                    foreach (m_blk[i]) if (model_hr(m_blk[i]) < mn) mn = model_hr(m_blk[i]);
                    m_sh  = 5'(mn);
                    m_sh8 = (mn > 8) ? 5'd8 : 5'(mn);
                    foreach (m_blk[i]) begin
                        m_q.push_back(m_blk[i] << m_sh);
                        m_q8.push_back(m_blk[i] << m_sh8);
                    end
                    m_drain = 1'b1;
                end
            end else if (m_drain && out_ready) begin
                void'(m_q.pop_front());
                void'(m_q8.pop_front());
                if (m_q.size() == 0) begin
                    m_drain = 1'b0;
                    m_blk.delete();
                end
            end
        end
    end

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            in_valid = 1'b1;
            in_data  = blk_in[i];
            @(negedge clk);
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) chk("push_timeout", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Pulls n outputs, pinning the first output's exponents and optionally a literal data word.
    task automatic drain(input int n, input int stall_idx, input logic [4:0] es,
                         input logic [4:0] es8, input bit use_lit, input logic [31:0] ed);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            if (i == stall_idx) begin
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            @(negedge clk);
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
            if (i == 0) begin
                chk("lit_shift", {27'd0, out_shift}, {27'd0, es});
                chk("lit_shift8", {27'd0, out_shift8}, {27'd0, es8});
            end
            chk("lit_data", out_data, blk_in[i] << es);
            if (use_lit) chk("lit_data_const", out_data, ed);
            chk("lit_last", {31'd0, out_last}, {31'd0, i == BL - 1});
            @(posedge clk); #1;
        end
        if (n == BL) begin
            @(negedge clk);
            chk("no_extra_output", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < BL; i++) blk_in[i] = 32'h0000_0100;
        push_n(BL);
        drain(BL, -1, 5'd22, 5'd8, 1'b1, 32'h4000_0000);

        for (int i = 0; i < BL; i++) blk_in[i] = 32'hFFFF_FF00;
        push_n(BL);
        drain(BL, -1, 5'd23, 5'd8, 1'b1, 32'h8000_0000);

        for (int i = 0; i < BL; i++) blk_in[i] = 32'h0000_0001;
        blk_in[BL-1] = 32'h4000_0000;
        push_n(BL);
        drain(BL, -1, 5'd0, 5'd0, 1'b0, 32'd0);

        for (int i = 0; i < BL; i++) blk_in[i] = 32'h0000_0000;
        push_n(BL);
        drain(BL, -1, 5'd31, 5'd8, 1'b1, 32'h0000_0000);

        for (int i = 0; i < BL; i++)
            blk_in[i] = (i % 2 == 0) ? 32'h0000_1000 + 32'(i) : 32'hFFFF_F000 - 32'(i);
        push_n(BL);
        drain(BL, 4, 5'd18, 5'd8, 1'b0, 32'd0);

        for (int i = 0; i < BL; i++) blk_in[i] = 32'h0000_0100;
        push_n(7);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h7FFF_FFFF;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        push_n(BL);
        drain(BL, -1, 5'd22, 5'd8, 1'b1, 32'h4000_0000);

        push_n(BL);
        drain(5, -1, 5'd22, 5'd8, 1'b1, 32'h4000_0000);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        push_n(BL);
        drain(BL, -1, 5'd22, 5'd8, 1'b1, 32'h4000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
